// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the Mandelbrot frame sequencer.
// Holds the coordinate format, raster dimension widths, Avalon register map
// and the sequencer state encoding.
package mandelbrot_pkg;

  localparam int COORD_W = 27;  // signed 4.23 fixed point
  localparam int FRAC_W  = 23;
  localparam int X_W     = 10;
  localparam int Y_W     = 10;

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_X0      = 3'd1;
  localparam logic [2:0] REG_Y0      = 3'd2;
  localparam logic [2:0] REG_DX      = 3'd3;
  localparam logic [2:0] REG_DY      = 3'd4;
  localparam logic [2:0] REG_SIZE    = 3'd5;
  localparam logic [2:0] REG_RETIRED = 3'd6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

endpackage

// File: rtl/mandelbrot_raster_walker.sv
// Row-major raster walker with incremental complex-coordinate accumulators.
// On load it captures the frame geometry and points at pixel (0,0); each
// advance steps one pixel, stepping c_re by dx along a row and returning it
// to x0 while stepping c_im by dy at the end of each row.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   load                  capture geometry and restart at (0,0)
//   advance               step to the next pixel (pixel accepted)
//   width, height         frame size
//   x0, y0, dx, dy        origin and per-pixel step
//   x, y, c_re, c_im      current pixel and its coordinate
//   last                  current pixel is (width-1, height-1)
module mandelbrot_raster_walker #(
  parameter int COORD_W = 27
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               advance,
  input  logic [9:0]         width,
  input  logic [9:0]         height,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] dx,
  input  logic [COORD_W-1:0] dy,
  output logic [9:0]         x,
  output logic [9:0]         y,
  output logic [COORD_W-1:0] c_re,
  output logic [COORD_W-1:0] c_im,
  output logic               last
);
  import mandelbrot_pkg::*;

  logic [X_W-1:0]     width_s;
  logic [Y_W-1:0]     height_s;
  logic [COORD_W-1:0] x0_s;
  logic [COORD_W-1:0] dx_s;
  logic [COORD_W-1:0] dy_s;
  logic               x_end;

  assign x_end = (x == width_s - X_W'(1));
  assign last  = x_end && (y == height_s - Y_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      width_s  <= '0;
      height_s <= '0;
      x0_s     <= '0;
      dx_s     <= '0;
      dy_s     <= '0;
      x        <= '0;
      y        <= '0;
      c_re     <= '0;
      c_im     <= '0;
    end else if (load) begin
      width_s  <= width;
      height_s <= height;
      x0_s     <= x0;
      dx_s     <= dx;
      dy_s     <= dy;
      x        <= '0;
      y        <= '0;
      c_re     <= x0;
      c_im     <= y0;
    end else if (advance) begin
      if (!x_end) begin
        x    <= x + X_W'(1);
        c_re <= c_re + dx_s;
      end else begin
        // row wrap: c_re restarts from the origin rather than accumulating
        x    <= '0;
        c_re <= x0_s;
        y    <= y + Y_W'(1);
        c_im <= c_im + dy_s;
      end
    end
  end

endmodule

// File: rtl/mandelbrot_frame_sequencer.sv
// Frame-level controller for the Mandelbrot renderer.
// An Avalon-MM slave holds shadow geometry registers; a start copies them into
// the raster walker, which then issues one pixel per handshake to the iterator
// pool. In-flight pixels are bounded by MAX_OUTSTANDING and the frame completes
// once the last pixel has been issued and every issued pixel has retired.
//
// state | meaning
// IDLE  | waiting for start; done/RETIRED show the last frame
// RUN   | issuing pixels
// DRAIN | all pixels issued, waiting for outstanding results
//
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   address, chipselect, write_n,
//   writedata, readdata                Avalon-MM slave, zero-latency read
//   pix_valid, pix_ready, pix_x, pix_y,
//   pix_c_re, pix_c_im                 pixel stream to the iterator pool
//   result_valid                       one pixel retired
//   busy, frame_done                   status; frame_done pulses on completion
module mandelbrot_frame_sequencer #(
  parameter int MAX_OUTSTANDING = 16,
  parameter int COORD_W         = 27
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [9:0]         pix_x,
  output logic [9:0]         pix_y,
  output logic [COORD_W-1:0] pix_c_re,
  output logic [COORD_W-1:0] pix_c_im,
  input  logic               result_valid,
  output logic               busy,
  output logic               frame_done
);
  import mandelbrot_pkg::*;

  localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

  seq_state_t         state, state_nxt;
  logic               finish;
  logic [COORD_W-1:0] x0_r, y0_r, dx_r, dy_r;
  logic [X_W-1:0]     width_r;
  logic [Y_W-1:0]     height_r;
  logic               done_r;
  logic [7:0]         outstanding;
  logic [19:0]        retired;
  logic               wr_en, ctrl_wr, start_cmd, abort_cmd, start_ok;
  logic               zero_dim, handshake, res_acc, last_pix;
  logic               unused_wdata;

  assign wr_en     = chipselect && !write_n;
  assign ctrl_wr   = wr_en && (address == REG_CTRL);
  assign abort_cmd = ctrl_wr && writedata[1];
  assign start_cmd = ctrl_wr && writedata[0] && !writedata[1];
  assign start_ok  = start_cmd && (state == IDLE);
  assign zero_dim  = (width_r == '0) || (height_r == '0);
  assign handshake = pix_valid && pix_ready;
  // a result with nothing in flight is spurious unless a pixel issues that cycle
  assign res_acc   = result_valid && (state != IDLE) &&
                     ((outstanding != 8'd0) || handshake);
  assign unused_wdata = ^{writedata[31:27], writedata[15:10]};

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          if (zero_dim) finish    = 1'b1;
          else          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort_cmd)                  state_nxt = IDLE;
        else if (handshake && last_pix) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (abort_cmd) begin
          state_nxt = IDLE;
        end else if ((outstanding == 8'd0) ||
                     ((outstanding == 8'd1) && res_acc)) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    busy      = (state != IDLE);
    pix_valid = (state == RUN) && (outstanding < MAX_OUT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_done  <= 1'b0;
      done_r      <= 1'b0;
      outstanding <= '0;
      retired     <= '0;
    end else begin
      frame_done <= finish;
      if (finish)        done_r <= 1'b1;
      else if (start_ok) done_r <= 1'b0;

      if (abort_cmd || start_ok) begin
        outstanding <= '0;
      end else if (handshake && !res_acc) begin
        outstanding <= outstanding + 8'd1;
      end else if (res_acc && !handshake) begin
        outstanding <= outstanding - 8'd1;
      end

      if (start_ok)     retired <= '0;
      else if (res_acc) retired <= retired + 20'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x0_r     <= '0;
      y0_r     <= '0;
      dx_r     <= '0;
      dy_r     <= '0;
      width_r  <= '0;
      height_r <= '0;
    end else if (wr_en) begin
      case (address)
        REG_X0:   x0_r <= writedata[COORD_W-1:0];
        REG_Y0:   y0_r <= writedata[COORD_W-1:0];
        REG_DX:   dx_r <= writedata[COORD_W-1:0];
        REG_DY:   dy_r <= writedata[COORD_W-1:0];
        REG_SIZE: begin
          width_r  <= writedata[9:0];
          height_r <= writedata[25:16];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      REG_CTRL:    readdata = {30'd0, done_r, busy};
      REG_X0:      readdata[COORD_W-1:0] = x0_r;
      REG_Y0:      readdata[COORD_W-1:0] = y0_r;
      REG_DX:      readdata[COORD_W-1:0] = dx_r;
      REG_DY:      readdata[COORD_W-1:0] = dy_r;
      REG_SIZE:    readdata = {6'd0, height_r, 6'd0, width_r};
      REG_RETIRED: readdata = {12'd0, retired};
      default:     readdata = '0;
    endcase
  end

  mandelbrot_raster_walker #(.COORD_W(COORD_W)) u_walker (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (start_ok),
    .advance (handshake),
    .width   (width_r),
    .height  (height_r),
    .x0      (x0_r),
    .y0      (y0_r),
    .dx      (dx_r),
    .dy      (dy_r),
    .x       (pix_x),
    .y       (pix_y),
    .c_re    (pix_c_re),
    .c_im    (pix_c_im),
    .last    (last_pix)
  );

endmodule

// File: doc/mandelbrot_frame_sequencer.md
# mandelbrot_frame_sequencer

Frame-level controller for the Mandelbrot renderer. An HPS-facing Avalon-MM slave holds the frame geometry: origin, per-pixel step and size. The block rasters every pixel in row-major order, computes each pixel's complex coordinate c incrementally in 27-bit fixed point, and issues the pixels to the iterator pool over a valid/ready stream. It tracks in-flight pixels and signals when the whole frame has completed.

## Interface
- MAX_OUTSTANDING, 16 — max pixels issued but not yet retired (1..255).
- COORD_W, 27 — coordinate width, signed 4.23 fixed point.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  combinational read data, zero-latency.
- pix_valid  out  1  pixel offer.
- pix_ready  in  1  pool accepts pixel.
- pix_x  out  10  pixel column.
- pix_y  out  10  pixel row.
- pix_c_re  out  27  real part of c.
- pix_c_im  out  27  imaginary part of c.
- result_valid  in  1  one pixel retired (one-cycle pulse per pixel).
- busy  out  1  state is not IDLE.
- frame_done  out  1  one-cycle pulse on normal frame completion.

## Operation
- Registers (write when chipselect & ~write_n):
  - 0 CTRL: write bit0=start, bit1=abort. Read {bit1 done, bit0 busy}.
  - 1 X0, 2 Y0, 3 DX, 4 DY: writedata[26:0]; reads return the value zero-extended to 32 bits.
  - 5 SIZE: [9:0] width, [25:16] height.
  - 6 RETIRED: read-only 20-bit count of pixels retired this frame.
  - 7: reads 0.
- Config registers are shadow registers and are writable at any time. Start snapshots them into working registers. Writes made while busy affect the next frame only.
- States: IDLE, RUN, DRAIN.
  - IDLE --start, width≠0 and height≠0--> RUN.
  - IDLE --start with a zero dimension--> stays IDLE; done set; frame_done pulses.
  - RUN --handshake on pixel (width-1, height-1)--> DRAIN.
  - DRAIN --outstanding==0--> IDLE; done set; frame_done pulses.
  - Any state --abort--> IDLE; done not set; outstanding cleared.
  - Abort and start written in the same write: abort wins.
  - Start while busy: ignored.
- Start clears done, RETIRED and outstanding. It loads x=0, y=0, c_re=X0, c_im=Y0.
- pix_valid = (state==RUN) & (outstanding < MAX_OUTSTANDING).
- Handshake = pix_valid & pix_ready. On each handshake:
  - If x < width-1: x+1, c_re += DX.
  - Else: x=0, c_re=X0, y+1, c_im += DY.
- Arithmetic: two's complement, wraps modulo 2^27, no saturation. DY is signed; software supplies a negative DY for top-down rendering.
- outstanding: +1 on handshake, -1 on result_valid, unchanged when both occur in the same cycle.
- result_valid while IDLE, or while outstanding==0 with no handshake that cycle: ignored (no underflow, RETIRED not incremented).
- RETIRED increments on every accepted result_valid.

## Timing
- Reset values:
  - state=IDLE, busy=0, pix_valid=0, frame_done=0, done=0.
  - pix_x=0, pix_y=0, pix_c_re=0, pix_c_im=0.
  - All config, outstanding and RETIRED = 0.
  - readdata reflects the reset register values.
- Start written in cycle n: busy=1 and pix_valid=1 in cycle n+1, with pixel (0,0), c=(X0,Y0).
- One pixel per cycle sustained while pix_ready=1 and outstanding < MAX_OUTSTANDING.
- While pix_valid=1 and pix_ready=0: pix_x, pix_y and c held stable. pix_valid never drops without a handshake, except on abort.
- Final result_valid in cycle m (with outstanding going 1→0): frame_done=1, done=1 and busy=0 in cycle m+1.
- Reset asserted mid-frame: immediate return to reset values; no frame_done pulse.

## Structure
- Package mandelbrot_pkg holds:
  - COORD_W=27, FRAC_W=23.
  - Register address constants REG_CTRL..REG_RETIRED.
  - State enum {IDLE, RUN, DRAIN}.
  - X_W=10, Y_W=10.
- Sub-module mandelbrot_raster_walker: x/y counters, c_re/c_im accumulators and last-pixel flag. Inputs are load, advance and the snapshotted config.
- Top level holds the Avalon decode, shadow registers, FSM, outstanding counter and RETIRED counter.

## Test plan
- 3×2 frame, X0=0x7000000 (-2.0), Y0=0x0800000 (1.0), DX=0x0200000 (0.25), DY=0x7C00000 (-0.5), pix_ready=1, each pixel retired 2 cycles after issue. Required:
  - Sequence (x,y,c_re,c_im) = (0,0,0x7000000,0x0800000), (1,0,0x7200000,0x0800000), (2,0,0x7400000,0x0800000), (0,1,0x7000000,0x0400000), …
  - One frame_done pulse; RETIRED=6; CTRL read returns 0x2.
- Backpressure: pix_ready=0 for 5 cycles mid-row. Required: outputs held stable; no pixel skipped or duplicated.
- MAX_OUTSTANDING=4, no result_valid: exactly 4 handshakes, then pix_valid=0. One result_valid then allows exactly one more handshake. Simultaneous handshake and result_valid leaves outstanding unchanged.
- Abort in RUN after 3 pixels: busy=0 next cycle, no frame_done, done=0. A subsequent start restarts from (0,0).
- SIZE=0 then start: frame_done pulses next cycle; zero handshakes occur.
- DX rewritten during a frame: the current frame uses the old DX; the next frame uses the new DX. Start while busy has no effect.
